// File: rtl/uart_rx_packetizer_if.sv
// Bus between the UART receiver, the packetizer and the ATC command decoder.
// The master drives received words and pkt_ready; the slave (packetizer)
// drives the packet outputs and the drop accounting.
interface uart_rx_packetizer_if #(
  parameter int PAYLOAD_WORDS = 3
);
  logic [8:0]                 rx_data;
  logic                       rx_done;
  logic                       rx_framing_error;
  logic                       pkt_valid;
  logic                       pkt_ready;
  logic [7:0]                 pkt_header;
  logic [PAYLOAD_WORDS*8-1:0] pkt_payload;
  logic                       pkt_dropped;
  logic [7:0]                 drop_count;

  modport master (
    output rx_data, rx_done, rx_framing_error, pkt_ready,
    input  pkt_valid, pkt_header, pkt_payload, pkt_dropped, drop_count
  );

  modport slave (
    input  rx_data, rx_done, rx_framing_error, pkt_ready,
    output pkt_valid, pkt_header, pkt_payload, pkt_dropped, drop_count
  );
endinterface

// File: rtl/uart_rx_packetizer.sv
// UART word packetizer: collects a header word (bit 8 set) plus
// PAYLOAD_WORDS data words into a packet, hands it to the consumer over
// valid/ready and discards/counts aborted or overflowing packets.
module uart_rx_packetizer #(
  parameter int PAYLOAD_WORDS  = 3,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_rx_packetizer_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST     = 4'(PAYLOAD_WORDS - 1);

  typedef enum logic [0:0] {HUNT, COLLECT} state_t;

  state_t                     state_reg, state_next;
  logic [3:0]                 idx_reg, idx_next;
  logic [TW-1:0]              timeout_reg, timeout_next;
  logic [7:0]                 header_reg, header_next;

  logic                       accept;
  logic                       store_en;
  logic                       complete;
  logic                       abort_drop;
  logic                       load_ok;
  logic                       load;
  logic                       drop_any;
  logic [PAYLOAD_WORDS*8-1:0] assembled;

  logic                       pkt_valid_reg;
  logic [7:0]                 pkt_header_reg;
  logic [PAYLOAD_WORDS*8-1:0] pkt_payload_reg;
  logic                       pkt_dropped_reg;
  logic [7:0]                 drop_count_reg;

  // A word with a framing error in the same cycle is never accepted.
  assign accept = bus.rx_done && !bus.rx_framing_error;

  // The output register can take a new packet if empty or being drained now.
  assign load_ok  = !pkt_valid_reg || bus.pkt_ready;
  assign load     = complete && load_ok;
  assign drop_any = abort_drop || (complete && !load_ok);

  // Payload slots; the word arriving this cycle is bypassed into the
  // assembled image so the final word can be loaded straight to the output.
  genvar gi;
  generate
    for (gi = 0; gi < PAYLOAD_WORDS; gi++) begin : g_slot
      logic [7:0] slot_reg;
      logic       slot_hit;
      assign slot_hit = store_en && (idx_reg == 4'(gi));
      assign assembled[(PAYLOAD_WORDS-1-gi)*8 +: 8] =
        slot_hit ? bus.rx_data[7:0] : slot_reg;
      // Capture the data byte destined for this slot.
      always_ff @(posedge clock) begin
        if (reset) slot_reg <= '0;
        else if (slot_hit) slot_reg <= bus.rx_data[7:0];
      end
    end
  endgenerate

  // Next-state logic: packet framing, abort priorities and timeout counting.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    timeout_next = timeout_reg;
    header_next  = header_reg;
    store_en     = 1'b0;
    complete     = 1'b0;
    abort_drop   = 1'b0;
    case (state_reg)
      HUNT: begin
        if (accept && bus.rx_data[8]) begin
          header_next  = bus.rx_data[7:0];
          idx_next     = '0;
          timeout_next = '0;
          state_next   = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.rx_framing_error) begin
          abort_drop   = 1'b1;
          idx_next     = '0;
          timeout_next = '0;
          state_next   = HUNT;
        end else if (!accept && (timeout_reg == TIMEOUT_LAST)) begin
          abort_drop   = 1'b1;
          idx_next     = '0;
          timeout_next = '0;
          state_next   = HUNT;
        end else if (accept && bus.rx_data[8]) begin
          // A fresh header kills the partial packet and restarts collection.
          abort_drop   = 1'b1;
          header_next  = bus.rx_data[7:0];
          idx_next     = '0;
          timeout_next = '0;
        end else if (accept) begin
          store_en     = 1'b1;
          timeout_next = '0;
          if (idx_reg == IDX_LAST) begin
            complete   = 1'b1;
            idx_next   = '0;
            state_next = HUNT;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end else begin
          timeout_next = timeout_reg + TW'(1);
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // Assembly-side state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= HUNT;
      idx_reg     <= '0;
      timeout_reg <= '0;
      header_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      timeout_reg <= timeout_next;
      header_reg  <= header_next;
    end
  end

  // Output register, handshake and saturating drop accounting.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_valid_reg   <= 1'b0;
      pkt_header_reg  <= '0;
      pkt_payload_reg <= '0;
      pkt_dropped_reg <= 1'b0;
      drop_count_reg  <= '0;
    end else begin
      if (load) begin
        pkt_valid_reg   <= 1'b1;
        pkt_header_reg  <= header_reg;
        pkt_payload_reg <= assembled;
      end else if (bus.pkt_ready) begin
        pkt_valid_reg <= 1'b0;
      end
      pkt_dropped_reg <= drop_any;
      if (drop_any && (drop_count_reg != 8'hFF))
        drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  assign bus.pkt_valid   = pkt_valid_reg;
  assign bus.pkt_header  = pkt_header_reg;
  assign bus.pkt_payload = pkt_payload_reg;
  assign bus.pkt_dropped = pkt_dropped_reg;
  assign bus.drop_count  = drop_count_reg;

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Bench for uart_rx_packetizer: a cycle table, directed corner sequences and
// a randomized run, all checked each cycle against a packet-level model.
module tb_uart_rx_packetizer;

  localparam int PW = 3;
  localparam int TO = 50;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  int   pulses  = 0;

  always #5 clock = ~clock;

  uart_rx_packetizer_if #(.PAYLOAD_WORDS(PW)) bus ();

  uart_rx_packetizer #(.PAYLOAD_WORDS(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Packet-level reference: the partial packet is a byte queue; the
  // delivered packet is whatever the consumer is currently offered.
  bit          m_in_pkt;
  logic [7:0]  m_hdr;
  logic [7:0]  m_bytes[$];
  int          m_idle;
  bit          m_valid;
  logic [7:0]  m_ohdr;
  logic [23:0] m_opay;
  bit          m_drop;
  int          m_cnt;

  function automatic void model_cycle(logic [8:0] d, bit done, bit fe, bit rdy, bit rst);
    bit drop = 0;
    bit finished = 0;
    logic [23:0] pay = '0;
    if (rst) begin
      m_in_pkt = 0; m_hdr = 0; m_bytes.delete(); m_idle = 0;
      m_valid = 0; m_ohdr = 0; m_opay = 0; m_drop = 0; m_cnt = 0;
      return;
    end
    if (m_in_pkt) begin
      if (fe) begin
        drop = 1; m_in_pkt = 0;
      end else if (!done && m_idle == TO - 1) begin
        drop = 1; m_in_pkt = 0;
      end else if (done && d[8]) begin
        drop = 1; m_hdr = d[7:0]; m_bytes.delete(); m_idle = 0;
      end else if (done) begin
        m_bytes.push_back(d[7:0]); m_idle = 0;
        if (m_bytes.size() == PW) begin finished = 1; m_in_pkt = 0; end
      end else begin
        m_idle++;
      end
    end else if (done && !fe && d[8]) begin
      m_in_pkt = 1; m_hdr = d[7:0]; m_bytes.delete(); m_idle = 0;
    end
    if (finished) begin
      foreach (m_bytes[k]) pay = (pay << 8) | 24'(m_bytes[k]);
      if (!m_valid || rdy) begin
        m_valid = 1; m_ohdr = m_hdr; m_opay = pay;
      end else begin
        drop = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_drop = drop;
    if (drop && m_cnt < 255) m_cnt++;
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endfunction

  // One clock: advance the model with the current inputs, then compare.
  task automatic step();
    model_cycle(bus.rx_data, bus.rx_done, bus.rx_framing_error, bus.pkt_ready, reset);
    @(posedge clock);
    #1;
    cycle++;
    if (bus.pkt_dropped) pulses++;
    check("valid",   64'(bus.pkt_valid),   64'(m_valid));
    check("header",  64'(bus.pkt_header),  64'(m_ohdr));
    check("payload", 64'(bus.pkt_payload), 64'(m_opay));
    check("dropped", 64'(bus.pkt_dropped), 64'(m_drop));
    check("count",   64'(bus.drop_count),  64'(m_cnt));
  endtask

  task automatic send_word(logic [8:0] w, int gap);
    bus.rx_data = w;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    repeat (gap) step();
  endtask

  typedef struct {
    logic [8:0]  data;
    bit          done;
    bit          fe;
    bit          exp_valid;
    logic [7:0]  exp_hdr;
    logic [23:0] exp_pay;
    bit          exp_drop;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[8];
  int   p0;

  initial begin
    // Nominal packet and HUNT-state filtering, pkt_ready held high.
    vecs[0] = '{9'h1A5, 1, 0, 0, 8'h00, 24'h000000, 0, 8'd0};
    vecs[1] = '{9'h011, 1, 0, 0, 8'h00, 24'h000000, 0, 8'd0};
    vecs[2] = '{9'h022, 1, 0, 0, 8'h00, 24'h000000, 0, 8'd0};
    vecs[3] = '{9'h033, 1, 0, 1, 8'hA5, 24'h112233, 0, 8'd0};
    vecs[4] = '{9'h000, 0, 0, 0, 8'hA5, 24'h112233, 0, 8'd0};
    vecs[5] = '{9'h044, 1, 0, 0, 8'hA5, 24'h112233, 0, 8'd0};
    vecs[6] = '{9'h1EE, 1, 1, 0, 8'hA5, 24'h112233, 0, 8'd0};
    vecs[7] = '{9'h055, 1, 0, 0, 8'hA5, 24'h112233, 0, 8'd0};

    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    bus.rx_framing_error = 1'b0;
    bus.pkt_ready = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("reset_valid", 64'(bus.pkt_valid), 64'd0);
    check("reset_count", 64'(bus.drop_count), 64'd0);

    // Table-driven nominal run.
    bus.pkt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = vecs[i].data;
      bus.rx_done = vecs[i].done;
      bus.rx_framing_error = vecs[i].fe;
      step();
      check($sformatf("vec%0d_valid", i),   64'(bus.pkt_valid),   64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_header", i),  64'(bus.pkt_header),  64'(vecs[i].exp_hdr));
      check($sformatf("vec%0d_payload", i), 64'(bus.pkt_payload), 64'(vecs[i].exp_pay));
      check($sformatf("vec%0d_dropped", i), 64'(bus.pkt_dropped), 64'(vecs[i].exp_drop));
      check($sformatf("vec%0d_count", i),   64'(bus.drop_count),  64'(vecs[i].exp_cnt));
    end
    bus.rx_done = 1'b0;
    bus.rx_framing_error = 1'b0;

    // Backpressure then overflow of a second packet.
    bus.pkt_ready = 1'b0;
    send_word(9'h101, 1); send_word(9'h00A, 1); send_word(9'h00B, 1); send_word(9'h00C, 1);
    check("bp_valid", 64'(bus.pkt_valid), 64'd1);
    check("bp_header", 64'(bus.pkt_header), 64'h01);
    send_word(9'h102, 1); send_word(9'h00D, 1); send_word(9'h00E, 1); send_word(9'h00F, 0);
    check("ovf_dropped", 64'(bus.pkt_dropped), 64'd1);
    check("ovf_count", 64'(bus.drop_count), 64'd1);
    check("ovf_header", 64'(bus.pkt_header), 64'h01);
    check("ovf_payload", 64'(bus.pkt_payload), 64'h0A0B0C);
    bus.pkt_ready = 1'b1;
    step();
    check("hs_valid", 64'(bus.pkt_valid), 64'd0);

    // Back-to-back: ready rises in the cycle the second packet completes.
    bus.pkt_ready = 1'b0;
    send_word(9'h101, 1); send_word(9'h021, 1); send_word(9'h022, 1); send_word(9'h023, 1);
    send_word(9'h102, 1); send_word(9'h031, 1); send_word(9'h032, 1);
    bus.pkt_ready = 1'b1;
    send_word(9'h033, 0);
    check("b2b_valid", 64'(bus.pkt_valid), 64'd1);
    check("b2b_header", 64'(bus.pkt_header), 64'h02);
    check("b2b_payload", 64'(bus.pkt_payload), 64'h313233);
    check("b2b_dropped", 64'(bus.pkt_dropped), 64'd0);
    step();

    // Framing error mid-packet, lasting three cycles.
    p0 = pulses;
    send_word(9'h1C3, 1); send_word(9'h044, 1);
    bus.rx_framing_error = 1'b1;
    repeat (3) step();
    bus.rx_framing_error = 1'b0;
    check("fe_pulses", 64'(pulses - p0), 64'd1);
    check("fe_count", 64'(bus.drop_count), 64'd2);
    send_word(9'h012, 1);
    send_word(9'h1C4, 1); send_word(9'h051, 1); send_word(9'h052, 1); send_word(9'h053, 0);
    check("fe_next_header", 64'(bus.pkt_header), 64'hC4);
    check("fe_next_payload", 64'(bus.pkt_payload), 64'h515253);
    check("fe_next_pulses", 64'(pulses - p0), 64'd1);

    // Timeout after exactly TO idle clocks, then abort by re-header.
    p0 = pulses;
    send_word(9'h1AA, 1); send_word(9'h001, 0);
    repeat (TO - 1) step();
    check("to_early", 64'(pulses - p0), 64'd0);
    step();
    check("to_pulse", 64'(bus.pkt_dropped), 64'd1);
    send_word(9'h1BB, 1); send_word(9'h001, 1); send_word(9'h1CC, 1);
    send_word(9'h00D, 1); send_word(9'h00E, 1); send_word(9'h00F, 0);
    check("rh_valid", 64'(bus.pkt_valid), 64'd1);
    check("rh_header", 64'(bus.pkt_header), 64'hCC);
    check("rh_payload", 64'(bus.pkt_payload), 64'h0D0E0F);
    check("rh_pulses", 64'(pulses - p0), 64'd2);
    check("rh_count", 64'(bus.drop_count), 64'd4);

    // Reset while collecting and while a packet is held.
    bus.pkt_ready = 1'b0;
    send_word(9'h1E1, 1); send_word(9'h061, 1); send_word(9'h062, 1); send_word(9'h063, 1);
    send_word(9'h1DD, 1); send_word(9'h001, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_valid", 64'(bus.pkt_valid), 64'd0);
    check("rst_header", 64'(bus.pkt_header), 64'd0);
    check("rst_payload", 64'(bus.pkt_payload), 64'd0);
    check("rst_count", 64'(bus.drop_count), 64'd0);
    step();
    check("rst_nopulse", 64'(bus.pkt_dropped), 64'd0);

    // Saturation: 300 header+framing-error aborts.
    for (int i = 0; i < 300; i++) begin
      send_word(9'h1F0, 0);
      bus.rx_framing_error = 1'b1;
      step();
      bus.rx_framing_error = 1'b0;
    end
    check("sat_count", 64'(bus.drop_count), 64'd255);

    // Randomized traffic with idle windows long enough to hit the timeout.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.rx_done = ($urandom_range(0, 2) == 0);
      bus.rx_data = {($urandom_range(0, 3) == 0), 8'($urandom)};
      bus.rx_framing_error = ($urandom_range(0, 60) == 0);
      bus.pkt_ready = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 999) == 0);
      if ((c % 700) > 10 && (c % 700) < 80) bus.rx_done = 1'b0;
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
